// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// ----------------------------------------------------------------------------
// Shares one external memory/IO bus between the execute unit's memory port
// (instruction fetch, data read, masked data write) and a single DMA
// requester. The core side uses level-held strobes acknowledged by one-cycle
// done pulses; the bus side is a registered req/ack handshake.
//
// Arbitration: core beats DMA, except when the core has won STARVE grants in
// a row while d_req was pending. Inside the core, write > read > fetch.
//
// FSM: IDLE (grant + latch) -> BUSY (hold bus, wait m_ack) -> RESP (pulse).
// Minimum access is 3 cycles. No grant is made in RESP, which gives the
// requester one cycle to drop its strobe after seeing its done pulse.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a bus watchdog. After
// TIMEOUT BUSY cycles without m_ack the access completes with read data of
// all ones and bus_err pulses together with the done/ack pulse. Without the
// macro BUSY waits indefinitely and bus_err is tied to 0.
//
// Parameters:
//   RV      datapath width (16 or 32)
//   VA      address width; bus word address is [VA-1:RV/16]
//   STARVE  max consecutive core grants while d_req is pending (1..255)
//   TIMEOUT watchdog limit in cycles (ARB_TIMEOUT_EN only)
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   c_ifetch/c_rstrobe/c_wmask core fetch / read / write requests (level)
//   c_addr, c_wdata, c_io      core address, write data, IO qualifier
//   c_idone/c_rdone/c_wdone    core completion pulses
//   c_rdata                    core read data, valid with c_idone/c_rdone
//   d_req, d_we                DMA request (level) and write flag
//   d_addr, d_wdata, d_wmask   DMA address, write data, byte enables
//   d_ack, d_rdata             DMA completion pulse and read data
//   m_req/m_we/m_io            bus request, write, IO qualifier
//   m_addr/m_wdata/m_wmask     bus address, write data, byte enables
//   m_ack, m_rdata             bus completion and read data
//   bus_err                    one-cycle watchdog timeout pulse
// ============================================================================
module mem_arbiter #(
    parameter int RV      = 32,
    parameter int VA      = RV,
    parameter int STARVE  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 c_ifetch,
    input  logic [1:0]           c_rstrobe,
    input  logic [RV/8-1:0]      c_wmask,
    input  logic [VA-1:RV/16]    c_addr,
    input  logic [RV-1:0]        c_wdata,
    input  logic                 c_io,
    output logic                 c_idone,
    output logic                 c_rdone,
    output logic                 c_wdone,
    output logic [RV-1:0]        c_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [VA-1:RV/16]    d_addr,
    input  logic [RV-1:0]        d_wdata,
    input  logic [RV/8-1:0]      d_wmask,
    output logic                 d_ack,
    output logic [RV-1:0]        d_rdata,

    output logic                 m_req,
    output logic                 m_we,
    output logic                 m_io,
    output logic [VA-1:RV/16]    m_addr,
    output logic [RV-1:0]        m_wdata,
    output logic [RV/8-1:0]      m_wmask,
    input  logic                 m_ack,
    input  logic [RV-1:0]        m_rdata,
    output logic                 bus_err
);

    localparam int SW = $clog2(STARVE + 1);

    // Elaboration-time guard on the parameter ranges the arbiter relies on.
    if (STARVE < 1 || STARVE > 255 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_arbiter: STARVE must be 1..255 and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    // Which requester owns the transaction in flight; selects the pulse.
    typedef enum logic [1:0] {
        SRC_FETCH,
        SRC_READ,
        SRC_WRITE,
        SRC_DMA
    } src_t;

    state_t              r_state;
    state_t              w_next;
    src_t                r_src;
    src_t                w_src;

    logic [SW-1:0]       r_starve;

    logic                r_m_req;
    logic                r_m_we;
    logic                r_m_io;
    logic [VA-1:RV/16]   r_m_addr;
    logic [RV-1:0]       r_m_wdata;
    logic [RV/8-1:0]     r_m_wmask;

    logic                r_c_idone;
    logic                r_c_rdone;
    logic                r_c_wdone;
    logic                r_d_ack;
    logic [RV-1:0]       r_c_rdata;
    logic [RV-1:0]       r_d_rdata;
    logic                r_bus_err;

    logic                w_c_wr;
    logic                w_c_rd;
    logic                w_core_req;
    logic                w_starved;
    logic                w_dma_win;
    logic                w_core_win;
    logic                w_grant;
    logic                w_finish;
    logic                w_timeout;
    logic [RV-1:0]       w_cap;

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    assign w_c_wr     = |c_wmask;
    assign w_c_rd     = |c_rstrobe;
    assign w_core_req = w_c_wr | w_c_rd | c_ifetch;
    assign w_starved  = (r_starve == SW'(STARVE));

    // DMA wins only when the core is silent or has used up its allowance.
    assign w_dma_win  = d_req & (~w_core_req | w_starved);
    assign w_core_win = w_core_req & ~w_dma_win;

    always_comb begin
        if (w_dma_win)   w_src = SRC_DMA;
        else if (w_c_wr) w_src = SRC_WRITE;
        else if (w_c_rd) w_src = SRC_READ;
        else             w_src = SRC_FETCH;
    end

    // A watchdog expiry looks like an ack carrying all-ones data.
    assign w_cap = m_ack ? m_rdata : '1;

    // ------------------------------------------------------------------
    // Bus watchdog
    // ------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (!reset)                 r_tcnt <= '0;
        else if (r_state == ST_BUSY) r_tcnt <= r_tcnt + TW'(1);
        else                        r_tcnt <= '0;
    end

    // r_tcnt counts completed BUSY cycles, so TIMEOUT-1 marks the last one.
    assign w_timeout = (r_state == ST_BUSY) && !m_ack &&
                       (r_tcnt == TW'(TIMEOUT - 1));
    assign bus_err   = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (latch).
        w_next   = r_state;
        w_grant  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_core_win || w_dma_win) begin
                    w_grant = 1'b1;
                    w_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ack || w_timeout) begin
                    w_finish = 1'b1;
                    w_next   = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts core grants made over a pending DMA.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset)
            r_starve <= '0;
        else if (w_grant && w_dma_win)
            r_starve <= '0;
        else if (!d_req)
            r_starve <= '0;
        else if (w_grant && w_core_win && !w_starved)
            r_starve <= r_starve + SW'(1);
    end

    // ------------------------------------------------------------------
    // Bus registers, completion pulses and captured read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src     <= SRC_FETCH;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_io    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wmask <= '0;
            r_c_idone <= 1'b0;
            r_c_rdone <= 1'b0;
            r_c_wdone <= 1'b0;
            r_d_ack   <= 1'b0;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
            r_bus_err <= 1'b0;
        end else begin
            // Pulses are high only in the cycle after w_finish (RESP).
            r_c_idone <= 1'b0;
            r_c_rdone <= 1'b0;
            r_c_wdone <= 1'b0;
            r_d_ack   <= 1'b0;
            r_bus_err <= 1'b0;

            if (w_grant) begin
                r_src   <= w_src;
                r_m_req <= 1'b1;
                if (w_dma_win) begin
                    r_m_we    <= d_we;
                    r_m_io    <= 1'b0;
                    r_m_addr  <= d_addr;
                    r_m_wdata <= d_wdata;
                    r_m_wmask <= d_we ? d_wmask : '1;
                end else begin
                    r_m_we    <= w_c_wr;
                    r_m_io    <= c_io;
                    r_m_addr  <= c_addr;
                    r_m_wdata <= c_wdata;
                    r_m_wmask <= w_c_wr ? c_wmask : '1;
                end
            end

            if (w_finish) begin
                r_m_req   <= 1'b0;
                r_bus_err <= ~m_ack;
                case (r_src)
                    SRC_FETCH: begin
                        r_c_idone <= 1'b1;
                        r_c_rdata <= w_cap;
                    end
                    SRC_READ: begin
                        r_c_rdone <= 1'b1;
                        r_c_rdata <= w_cap;
                    end
                    SRC_WRITE: r_c_wdone <= 1'b1;
                    SRC_DMA: begin
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= w_cap;
                    end
                    default: r_c_idone <= 1'b0;
                endcase
            end
        end
    end

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_io    = r_m_io;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wmask = r_m_wmask;
    assign c_idone = r_c_idone;
    assign c_rdone = r_c_rdone;
    assign c_wdone = r_c_wdone;
    assign c_rdata = r_c_rdata;
    assign d_ack   = r_d_ack;
    assign d_rdata = r_d_rdata;

endmodule
